// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg / cache_ctrl
//  Description : Direct-mapped, one-word-per-line, write-back, write-allocate
//                cache controller. All outputs registered; one outstanding
//                memory read at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;
    localparam int ADDR_WIDTH  = 6;
    localparam int DATA_WIDTH  = 8;
    localparam int INDEX_WIDTH = 3;

    localparam logic [1:0] OP_INVALID = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
endpackage

module cache_ctrl #(
    parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = cache_pkg::DATA_WIDTH,
    parameter int INDEX_WIDTH = cache_pkg::INDEX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            mem_req_op,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    input  logic                  mem_rsp_vld,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data
);

    localparam int c_TAG_W = ADDR_WIDTH - INDEX_WIDTH;
    localparam int c_LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Line storage: valid/dirty are reset, tag/data are not
    logic [c_LINES-1:0]    r_valid;
    logic [c_LINES-1:0]    r_dirty;
    logic [c_TAG_W-1:0]    r_tag       [c_LINES];
    logic [DATA_WIDTH-1:0] r_line_data [c_LINES];

    // Request captured at acceptance, used by WRITEBACK/FILL
    logic                  r_pend_wr;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0] r_pend_data;

    // Registered outputs
    logic                  r_rsp_vld;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [1:0]            r_mem_op;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data;

    // Next-state values from the FSM combinational process
    logic                   w_rsp_vld_nxt;
    logic [DATA_WIDTH-1:0]  w_rsp_data_nxt;
    logic [1:0]             w_mem_op_nxt;
    logic [ADDR_WIDTH-1:0]  w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]  w_mem_data_nxt;
    logic                   w_capture;
    logic                   w_wr_en;
    logic                   w_wr_dirty;
    logic [INDEX_WIDTH-1:0] w_wr_idx;
    logic [c_TAG_W-1:0]     w_wr_tag;
    logic [DATA_WIDTH-1:0]  w_wr_data;

    // Address decode of the incoming and the pending request
    logic                   w_req;
    logic                   w_req_is_wr;
    logic [INDEX_WIDTH-1:0] w_req_idx;
    logic [c_TAG_W-1:0]     w_req_tag;
    logic                   w_hit;
    logic                   w_victim_dirty;
    logic [INDEX_WIDTH-1:0] w_pend_idx;
    logic [c_TAG_W-1:0]     w_pend_tag;

    assign w_req          = (req_op != cache_pkg::OP_INVALID);
    assign w_req_is_wr    = (req_op == cache_pkg::OP_WRITE);
    assign w_req_idx      = req_addr[INDEX_WIDTH-1:0];
    assign w_req_tag      = req_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_hit          = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_victim_dirty = r_valid[w_req_idx] && r_dirty[w_req_idx];
    assign w_pend_idx     = r_pend_addr[INDEX_WIDTH-1:0];
    assign w_pend_tag     = r_pend_addr[ADDR_WIDTH-1:INDEX_WIDTH];

    assign rsp_vld      = r_rsp_vld;
    assign rsp_data     = r_rsp_data;
    assign mem_req_op   = r_mem_op;
    assign mem_req_addr = r_mem_addr;
    assign mem_req_data = r_mem_data;

    // Next-state, next-output and line-update decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_rsp_vld_nxt  = 1'b0;
        w_rsp_data_nxt = r_rsp_data;
        w_mem_op_nxt   = cache_pkg::OP_INVALID;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        w_capture      = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_dirty     = 1'b0;
        w_wr_idx       = w_req_idx;
        w_wr_tag       = w_req_tag;
        w_wr_data      = req_data;
        case (r_state)
            ST_READY: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (w_req_is_wr) begin
                            w_wr_en    = 1'b1;
                            w_wr_dirty = 1'b1;
                        end else begin
                            w_rsp_vld_nxt  = 1'b1;
                            w_rsp_data_nxt = r_line_data[w_req_idx];
                        end
                    end else if (w_victim_dirty) begin
                        // Evict first; the request itself completes afterwards
                        w_capture      = 1'b1;
                        w_mem_op_nxt   = cache_pkg::OP_WRITE;
                        w_mem_addr_nxt = {r_tag[w_req_idx], w_req_idx};
                        w_mem_data_nxt = r_line_data[w_req_idx];
                        w_state_nxt    = ST_WRITEBACK;
                    end else if (w_req_is_wr) begin
                        w_wr_en    = 1'b1;
                        w_wr_dirty = 1'b1;
                    end else begin
                        w_capture      = 1'b1;
                        w_mem_op_nxt   = cache_pkg::OP_READ;
                        w_mem_addr_nxt = req_addr;
                        w_state_nxt    = ST_FILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (r_pend_wr) begin
                    w_wr_en     = 1'b1;
                    w_wr_dirty  = 1'b1;
                    w_wr_idx    = w_pend_idx;
                    w_wr_tag    = w_pend_tag;
                    w_wr_data   = r_pend_data;
                    w_state_nxt = ST_READY;
                end else begin
                    w_mem_op_nxt   = cache_pkg::OP_READ;
                    w_mem_addr_nxt = r_pend_addr;
                    w_state_nxt    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rsp_vld) begin
                    w_wr_en        = 1'b1;
                    w_wr_idx       = w_pend_idx;
                    w_wr_tag       = w_pend_tag;
                    w_wr_data      = mem_rsp_data;
                    w_rsp_vld_nxt  = 1'b1;
                    w_rsp_data_nxt = mem_rsp_data;
                    w_state_nxt    = ST_READY;
                end
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_READY;
        else     r_state <= w_state_nxt;
    end

    // Outputs, line valid/dirty bits and captured request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_op    <= cache_pkg::OP_INVALID;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_pend_wr   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_rsp_vld  <= w_rsp_vld_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_mem_op   <= w_mem_op_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
            if (w_wr_en) begin
                r_valid[w_wr_idx] <= 1'b1;
                r_dirty[w_wr_idx] <= w_wr_dirty;
            end
            if (w_capture) begin
                r_pend_wr   <= w_req_is_wr;
                r_pend_addr <= req_addr;
                r_pend_data <= req_data;
            end
        end
    end

    // Tag and data arrays (contents qualified by valid bits, not reset)
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_wr_idx]       <= w_wr_tag;
            r_line_data[w_wr_idx] <= w_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_ctrl
//  Description : Directed and random self-checking bench for cache_ctrl with
//                a backing memory that answers reads two cycles later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_op;
    logic [5:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_vld;
    logic [7:0] rsp_data;
    logic [1:0] mem_req_op;
    logic [5:0] mem_req_addr;
    logic [7:0] mem_req_data;
    logic       mem_rsp_vld;
    logic [7:0] mem_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem     [64];
    logic [7:0] ref_mem [64];
    int         rd_cnt = 0;
    logic [5:0] rd_addr = '0;
    int         n_mem_wr = 0;
    int         n_mem_rd = 0;

    cache_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsp_vld      (rsp_vld),
        .rsp_data     (rsp_data),
        .mem_req_op   (mem_req_op),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_rsp_vld  (mem_rsp_vld),
        .mem_rsp_data (mem_rsp_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then act as the memory for the cycle now visible
    task automatic step();
        @(posedge clk);
        #1;
        mem_rsp_vld = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rsp_vld  = 1'b1;
                mem_rsp_data = mem[rd_addr];
            end
        end
        if (mem_req_op == 2'd1) begin
            rd_cnt  = 2;
            rd_addr = mem_req_addr;
            n_mem_rd++;
        end else if (mem_req_op == 2'd2) begin
            mem[mem_req_addr] = mem_req_data;
            n_mem_wr++;
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d);
        req_op   = op;
        req_addr = a;
        req_data = d;
        step();
        req_op   = 2'd0;
    endtask

    task automatic wait_rsp(input string tag, output logic [7:0] d);
        bit got;
        got = 1'b0;
        d   = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_vld) begin
                got = 1'b1;
                d   = rsp_data;
            end else begin
                step();
            end
        end
        check_eq({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rsp_vld"},  32'(rsp_vld),      32'd0);
        check_eq({tag, "_rsp_data"}, 32'(rsp_data),     32'd0);
        check_eq({tag, "_mem_op"},   32'(mem_req_op),   32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_req_addr), 32'd0);
        check_eq({tag, "_mem_data"}, 32'(mem_req_data), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [5:0] a;
        logic [7:0] wd;
        int         wr_snap;
        int         rd_snap;

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        rst          = 1'b1;
        req_op       = 2'd0;
        req_addr     = '0;
        req_data     = '0;
        mem_rsp_vld  = 1'b0;
        mem_rsp_data = '0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Read miss on a clean line, then a hit on the same address
        do_req(2'd1, 6'h05, 8'h00);
        check_eq("rd05_mem_op",   32'(mem_req_op),   32'd1);
        check_eq("rd05_mem_addr", 32'(mem_req_addr), 32'h05);
        wait_rsp("rd05", d);
        check_eq("rd05_data", 32'(d), 32'h00);
        rd_snap = n_mem_rd;
        do_req(2'd1, 6'h05, 8'h00);
        check_eq("rd05hit_vld",    32'(rsp_vld),    32'd1);
        check_eq("rd05hit_data",   32'(rsp_data),   32'h00);
        check_eq("rd05hit_mem_op", 32'(mem_req_op), 32'd0);
        step();
        check_eq("rd05hit_nomem", 32'(n_mem_rd - rd_snap), 32'd0);

        // Write miss on a clean line, then read hit
        do_req(2'd2, 6'h0A, 8'h3C);
        check_eq("wr0A_mem_op",  32'(mem_req_op), 32'd0);
        check_eq("wr0A_rsp_vld", 32'(rsp_vld),    32'd0);
        step();
        check_eq("wr0A_mem_op2", 32'(mem_req_op), 32'd0);
        do_req(2'd1, 6'h0A, 8'h00);
        check_eq("rd0A_vld",  32'(rsp_vld),  32'd1);
        check_eq("rd0A_data", 32'(rsp_data), 32'h3C);

        // Conflicting write evicts the dirty line
        do_req(2'd2, 6'h12, 8'h77);
        check_eq("wr12_wb_op",   32'(mem_req_op),   32'd2);
        check_eq("wr12_wb_addr", 32'(mem_req_addr), 32'h0A);
        check_eq("wr12_wb_data", 32'(mem_req_data), 32'h3C);
        step();
        check_eq("wr12_wb_once", 32'(mem_req_op), 32'd0);
        do_req(2'd1, 6'h0A, 8'h00);
        check_eq("rd0A_wb_op",   32'(mem_req_op),   32'd2);
        check_eq("rd0A_wb_addr", 32'(mem_req_addr), 32'h12);
        check_eq("rd0A_wb_data", 32'(mem_req_data), 32'h77);
        step();
        check_eq("rd0A_rd_op",   32'(mem_req_op),   32'd1);
        check_eq("rd0A_rd_addr", 32'(mem_req_addr), 32'h0A);
        wait_rsp("rd0A_fill", d);
        check_eq("rd0A_fill_data", 32'(d), 32'h3C);

        // Requests during FILL are ignored
        do_req(2'd1, 6'h21, 8'h00);
        check_eq("rd21_op", 32'(mem_req_op), 32'd1);
        do_req(2'd2, 6'h29, 8'h55);
        wait_rsp("rd21", d);
        check_eq("rd21_data", 32'(d), 32'h00);
        step();
        wr_snap = n_mem_wr;
        do_req(2'd1, 6'h29, 8'h00);
        check_eq("rd29_op",   32'(mem_req_op),   32'd1);
        check_eq("rd29_addr", 32'(mem_req_addr), 32'h29);
        wait_rsp("rd29", d);
        check_eq("rd29_data",   32'(d), 32'h00);
        check_eq("rd29_no_wb",  32'(n_mem_wr - wr_snap), 32'd0);
        step();

        // Reset during FILL aborts the read; late response is ignored
        mem[7] = 8'h99;
        do_req(2'd1, 6'h07, 8'h00);
        check_eq("rd07_op",   32'(mem_req_op),   32'd1);
        check_eq("rd07_addr", 32'(mem_req_addr), 32'h07);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        #1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("late_rsp_vld", 32'(rsp_vld),    32'd0);
            check_eq("late_mem_op",  32'(mem_req_op), 32'd0);
        end
        do_req(2'd1, 6'h07, 8'h00);
        check_eq("rd07_again_op",   32'(mem_req_op),   32'd1);
        check_eq("rd07_again_addr", 32'(mem_req_addr), 32'h07);
        wait_rsp("rd07_again", d);
        check_eq("rd07_again_data", 32'(d), 32'h99);

        // Random traffic against a reference memory image
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rd_cnt = 0;
        step();
        for (int t = 0; t < 1000; t++) begin
            a  = 6'($urandom_range(0, 63));
            wd = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                do_req(2'd2, a, wd);
                ref_mem[a] = wd;
            end else begin
                do_req(2'd1, a, 8'h00);
                wait_rsp("rnd", d);
                check_eq("rnd_data", 32'(d), 32'(ref_mem[a]));
            end
            repeat (3 + $urandom_range(0, 2)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, 6, word-address width; taken from cache_pkg.
REQ-002 Parameter DATA_WIDTH, 8, word width; taken from cache_pkg.
REQ-003 Parameter INDEX_WIDTH, 3, line index width; 2^INDEX_WIDTH lines; INDEX_WIDTH < ADDR_WIDTH.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_op  in  2  processor op: Op_INVALID=0, Op_READ=1, Op_WRITE=2; valid for one cycle per request.
REQ-007 req_addr  in  ADDR_WIDTH  processor word address.
REQ-008 req_data  in  DATA_WIDTH  processor write data.
REQ-009 rsp_vld  out  1  read response valid, one-cycle pulse.
REQ-010 rsp_data  out  DATA_WIDTH  read response data, meaningful only when rsp_vld=1.
REQ-011 mem_req_op  out  2  memory op, same encoding, one-cycle pulse per request.
REQ-012 mem_req_addr  out  ADDR_WIDTH  memory word address.
REQ-013 mem_req_data  out  DATA_WIDTH  memory write data.
REQ-014 mem_rsp_vld  in  1  memory read data valid, one-cycle pulse, any latency >= 1 cycle.
REQ-015 mem_rsp_data  in  DATA_WIDTH  memory read data.

Function
REQ-016 Direct-mapped, one word per line, write-back, write-allocate; index = addr[INDEX_WIDTH-1:0], tag = remaining upper bits; per line: valid, dirty, tag, data.
REQ-017 All outputs registered; states READY, WRITEBACK, FILL.
REQ-018 Requests (req_op != Op_INVALID) sampled only in READY; requests in other states ignored, no state change.
REQ-019 Read hit: rsp_vld=1 with line data in the cycle after the request; no memory traffic; state stays READY.
REQ-020 Write hit: line data updated, dirty set, no response, no memory traffic.
REQ-021 Miss with victim valid and dirty: next cycle mem_req_op=Op_WRITE, mem_req_addr={victim tag, index}, mem_req_data=victim data, one cycle (WRITEBACK); memory writes are posted, no acknowledge.
REQ-022 Write miss: line installed with new tag and req_data, valid=1, dirty=1, in the request cycle (clean victim) or the WRITEBACK cycle (dirty victim); returns to READY; no memory read.
REQ-023 Read miss: mem_req_op=Op_READ with mem_req_addr=req_addr issued in the cycle after the request (clean victim) or after the WRITEBACK cycle (dirty victim); enters FILL.
REQ-024 FILL: on mem_rsp_vld, line installed valid=1, dirty=0, data=mem_rsp_data; next cycle rsp_vld=1, rsp_data=mem_rsp_data; return to READY.
REQ-025 Request address/data captured at acceptance; req_* changes during WRITEBACK/FILL have no effect.
REQ-026 mem_rsp_vld outside FILL ignored.
REQ-027 At most one outstanding memory read; mem_req_op=Op_INVALID in all cycles other than REQ-021/REQ-023 pulses.

Reset
REQ-028 rst=1 immediately: state READY, all valid and dirty bits 0, rsp_vld=0, rsp_data=0, mem_req_op=Op_INVALID, mem_req_addr=0, mem_req_data=0; tag/data arrays not reset.
REQ-029 Reset during WRITEBACK or FILL aborts the operation; no rsp_vld for the aborted read; late mem_rsp_vld after reset ignored.
REQ-030 First request accepted in the first cycle with rst=0.

Verification (defaults, memory model responds 2 cycles after read request)
REQ-031 After reset, read 0x05 -> mem READ 0x05 next cycle; memory returns 0x00 -> rsp_vld, rsp_data=0x00; re-read 0x05 -> rsp_vld next cycle, no mem traffic.
REQ-032 Write 0x0A data 0x3C -> no mem traffic; read 0x0A -> hit, rsp_data=0x3C one cycle later.
REQ-033 Then write 0x12 data 0x77 -> one-cycle mem WRITE addr 0x0A data 0x3C; read 0x0A -> mem WRITE 0x12/0x77, then mem READ 0x0A; returned 0x3C -> rsp_data=0x3C.
REQ-034 Read 0x21 miss; while in FILL drive write 0x29/0x55 -> ignored; after fill, read 0x29 -> miss with mem READ 0x29, no writeback.
REQ-035 Read 0x07 miss; assert rst during FILL; memory then returns 0x99 -> no rsp_vld, all outputs at reset values; read 0x07 -> miss again.
REQ-036 Random 1000-transaction run against a reference memory array, >= 3 idle cycles between requests -> every read rsp_data equals last written value (0 if never written).
